// File: rtl/fht_adc_loader.sv
// ADC front-end for fht_top: converts signed samples to FHT fixed point and fills the four RAM banks round-robin.
// Optional FHT_LOADER_BIT_REV_EN: store each bank in bit-reversed address order (natural order when undefined).
module fht_adc_loader #(
    parameter int D_BIT     = 22,
    parameter int ADC_WIDTH = 16,
    parameter int A_BIT     = 8
) (
    input  logic                 iCLK,
    input  logic                 iRESET,
    input  logic                 iVALID,
    input  logic [ADC_WIDTH-1:0] iADC,
    output logic                 oREADY,
    output logic [D_BIT-1:0]     oDATA,
    output logic [A_BIT-1:0]     oADDR,
    output logic [3:0]           oWE,
    output logic                 oSTART,
    input  logic                 iFHT_RDY,
    output logic                 oOVF,
    input  logic                 iCLR_OVF
);

    localparam int CNT_W = A_BIT + 2;
    localparam int SHIFT = D_BIT - ADC_WIDTH;

    typedef enum logic [1:0] {
        S_LOAD,
        S_FLUSH,
        S_START,
        S_BUSY
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt_p0;
    logic             vld_p0;
    logic             frame_end_p0;
    logic             ovr_p0;
    logic             rdy_p1, rdy_p2;
    logic             rdy_rise_p2;

    // Sample becomes the integer part; fractional bits are zero.
    function automatic logic [D_BIT-1:0] to_fixed(input logic signed [ADC_WIDTH-1:0] s);
        logic signed [D_BIT-1:0] ext;
        ext = D_BIT'(s);
        return ext <<< SHIFT;
    endfunction

    function automatic logic [A_BIT-1:0] map_addr(input logic [A_BIT-1:0] a);
        logic [A_BIT-1:0] r;
`ifdef FHT_LOADER_BIT_REV_EN
        for (int i = 0; i < A_BIT; i++) begin
            r[i] = a[A_BIT-1-i];
        end
`else
        r = a;
`endif
        return r;
    endfunction

    assign vld_p0       = iVALID && oREADY;
    assign frame_end_p0 = vld_p0 && (cnt_p0 == {CNT_W{1'b1}});
    assign ovr_p0       = iVALID && (state != S_LOAD);
    // Edge register resets high so an idle-high FHT ready never looks like a completion.
    assign rdy_rise_p2  = rdy_p1 && !rdy_p2;

    always_comb begin
        state_nxt = state;
        case (state)
            S_LOAD:  if (frame_end_p0) state_nxt = S_FLUSH;
            S_FLUSH: state_nxt = S_START;
            S_START: state_nxt = S_BUSY;
            S_BUSY:  if (rdy_rise_p2) state_nxt = S_LOAD;
            default: state_nxt = S_LOAD;
        endcase
    end

    // Stage p0 -> registered outputs
    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            state  <= S_LOAD;
            cnt_p0 <= '0;
            rdy_p1 <= 1'b1;
            rdy_p2 <= 1'b1;
            oREADY <= 1'b1;
            oSTART <= 1'b0;
            oWE    <= 4'b0000;
            oADDR  <= '0;
            oDATA  <= '0;
            oOVF   <= 1'b0;
        end else begin
            state  <= state_nxt;
            rdy_p1 <= iFHT_RDY;
            rdy_p2 <= rdy_p1;
            oREADY <= (state_nxt == S_LOAD);
            oSTART <= (state_nxt == S_START);
            oWE    <= vld_p0 ? (4'b0001 << cnt_p0[1:0]) : 4'b0000;
            if (vld_p0) begin
                cnt_p0 <= cnt_p0 + CNT_W'(1);
                oDATA  <= to_fixed(iADC);
                oADDR  <= map_addr(cnt_p0[CNT_W-1:2]);
            end
            // A new overrun in the same cycle as a clear must stay visible.
            if (ovr_p0) begin
                oOVF <= 1'b1;
            end else if (iCLR_OVF) begin
                oOVF <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fht_adc_loader.sv
// Directed bench for fht_adc_loader (A_BIT=2, 16-sample frames) with a write scoreboard.
module tb_fht_adc_loader;

    localparam int D_BIT     = 22;
    localparam int ADC_WIDTH = 16;
    localparam int A_BIT     = 2;

    logic                 iCLK = 1'b0;
    logic                 iRESET;
    logic                 iVALID;
    logic [ADC_WIDTH-1:0] iADC;
    logic                 oREADY;
    logic [D_BIT-1:0]     oDATA;
    logic [A_BIT-1:0]     oADDR;
    logic [3:0]           oWE;
    logic                 oSTART;
    logic                 iFHT_RDY;
    logic                 oOVF;
    logic                 iCLR_OVF;

    typedef struct {
        logic [3:0]       we;
        logic [A_BIT-1:0] addr;
        logic [D_BIT-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_cmp = 0;
    int  n_mis = 0;
    int  tb_cnt = 0;

    fht_adc_loader #(.D_BIT(D_BIT), .ADC_WIDTH(ADC_WIDTH), .A_BIT(A_BIT)) dut (
        .iCLK(iCLK), .iRESET(iRESET), .iVALID(iVALID), .iADC(iADC), .oREADY(oREADY),
        .oDATA(oDATA), .oADDR(oADDR), .oWE(oWE), .oSTART(oSTART), .iFHT_RDY(iFHT_RDY),
        .oOVF(oOVF), .iCLR_OVF(iCLR_OVF)
    );

    always #5 iCLK = ~iCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [A_BIT-1:0] exp_addr(input int c);
        logic [A_BIT-1:0] a;
        a = A_BIT'(c / 4);
`ifdef FHT_LOADER_BIT_REV_EN
        return {a[0], a[1]};
`else
        return a;
`endif
    endfunction

    task automatic step();
        @(posedge iCLK);
        #1;
    endtask

    // Drive one sample for one clock; record the expected write only if the loader is ready.
    task automatic send(input logic [ADC_WIDTH-1:0] v);
        wr_t e;
        iVALID = 1'b1;
        iADC   = v;
        if (oREADY) begin
            e.we   = 4'b0001 << (tb_cnt % 4);
            e.addr = exp_addr(tb_cnt);
            e.data = {v, 6'b000000};
            exp_q.push_back(e);
            tb_cnt = (tb_cnt + 1) % 16;
        end
        step();
        iVALID = 1'b0;
    endtask

    always @(negedge iCLK) begin
        if (oWE !== 4'b0000) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'(oWE), 32'h0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_we", 32'(oWE), 32'(e.we));
                check("wr_addr", 32'(oADDR), 32'(e.addr));
                check("wr_data", 32'(oDATA), 32'(e.data));
            end
        end
    end

    initial begin
        logic [A_BIT-1:0] a4, a5, a13;
`ifdef FHT_LOADER_BIT_REV_EN
        a4 = 2; a5 = 2; a13 = 3;
`else
        a4 = 1; a5 = 1; a13 = 3;
`endif
        iRESET = 1'b1; iVALID = 1'b0; iADC = '0; iFHT_RDY = 1'b1; iCLR_OVF = 1'b0;
        step();
        step();
        check("rst_ready", 32'(oREADY), 32'h1);
        check("rst_data", 32'(oDATA), 32'h0);
        check("rst_addr", 32'(oADDR), 32'h0);
        check("rst_we", 32'(oWE), 32'h0);
        check("rst_start", 32'(oSTART), 32'h0);
        check("rst_ovf", 32'(oOVF), 32'h0);
        iRESET = 1'b0;
        check("rel_ready", 32'(oREADY), 32'h1);

        // Frame 1: 0..15 back-to-back
        for (int i = 0; i < 16; i++) begin
            send(16'(i));
            if (i == 4) begin
                check("s4_we", 32'(oWE), 32'h1);
                check("s4_addr", 32'(oADDR), 32'(a4));
            end
            if (i == 5) begin
                check("s5_we", 32'(oWE), 32'h2);
                check("s5_addr", 32'(oADDR), 32'(a5));
                check("s5_data", 32'(oDATA), 32'h140);
            end
            if (i == 13) check("s13_addr", 32'(oADDR), 32'(a13));
        end
        check("flush_ready", 32'(oREADY), 32'h0);
        check("flush_start", 32'(oSTART), 32'h0);
        step();
        check("start_pulse", 32'(oSTART), 32'h1);
        step();
        check("start_gone", 32'(oSTART), 32'h0);
        check("busy_ready", 32'(oREADY), 32'h0);

        // Overrun in BUSY, FHT ready held high since START
        send(16'h5555);
        check("ovr_set", 32'(oOVF), 32'h1);
        check("ovr_no_we", 32'(oWE), 32'h0);
        repeat (4) step();
        check("busy_hold", 32'(oREADY), 32'h0);
        iVALID = 1'b1; iCLR_OVF = 1'b1;
        step();
        check("ovr_set_wins", 32'(oOVF), 32'h1);
        iVALID = 1'b0;
        step();
        check("ovr_cleared", 32'(oOVF), 32'h0);
        iCLR_OVF = 1'b0;
        iFHT_RDY = 1'b0;
        step();
        step();
        check("busy_low", 32'(oREADY), 32'h0);
        iFHT_RDY = 1'b1;
        step();
        check("edge_R", 32'(oREADY), 32'h0);
        step();
        check("load_R1", 32'(oREADY), 32'h1);

        // Frame 2: negative sample, stalled valid, then reset after 7 samples
        send(16'h8000);
        check("neg_we", 32'(oWE), 32'h1);
        check("neg_data", 32'(oDATA), 32'h200000);
        iADC = 16'h1234;
        step();
        check("stall_no_we", 32'(oWE), 32'h0);
        send(16'h7FFF);
        check("pos_max", 32'(oDATA), 32'h1FFFC0);
        send(16'hFFFF);
        check("neg_one", 32'(oDATA), 32'h3FFFC0);
        for (int i = 0; i < 4; i++) send(16'($urandom_range(0, 65535)));
        @(negedge iCLK);
        #1;
        check("mid_drain", 32'(exp_q.size()), 32'h0);
        iRESET = 1'b1;
        #1;
        check("arst_we", 32'(oWE), 32'h0);
        check("arst_addr", 32'(oADDR), 32'h0);
        check("arst_data", 32'(oDATA), 32'h0);
        check("arst_ready", 32'(oREADY), 32'h1);
        tb_cnt = 0;
        step();
        iRESET = 1'b0;

        // Frame 3: fresh frame after reset
        for (int i = 0; i < 16; i++) begin
            send(16'($urandom_range(0, 65535)));
            if (i == 0) begin
                check("f3_first_we", 32'(oWE), 32'h1);
                check("f3_first_addr", 32'(oADDR), 32'h0);
            end
            if (i < 15) check("f3_no_start", 32'(oSTART), 32'h0);
        end
        check("f3_flush", 32'(oSTART), 32'h0);
        step();
        check("f3_start", 32'(oSTART), 32'h1);
        step();
        check("f3_busy", 32'(oREADY), 32'h0);
        step();
        check("end_drain", 32'(exp_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/fht_adc_loader.md
# fht_adc_loader

Front-end stage feeding `fht_top`. It accepts a stream of signed ADC samples under a valid/ready handshake and converts each sample to the FHT fixed-point format. It writes consecutive samples round-robin into the four RAM banks (bank = sample index mod 4, address = index div 4). After a full frame it issues the one-cycle start pulse, then blocks new input until the FHT reports completion.

## Interface
Parameters:
- `D_BIT`, 22, FHT data width; must be ≥ `ADC_WIDTH`
- `ADC_WIDTH`, 16, signed ADC sample width
- `A_BIT`, 8, bank address width; bank depth = 2**A_BIT, frame = 4·2**A_BIT samples

Ports:
- `iCLK` in 1: clock
- `iRESET` in 1: asynchronous, active-high reset
- `iVALID` in 1: ADC sample valid
- `iADC` in ADC_WIDTH: signed sample
- `oREADY` out 1: loader can accept a sample
- `oDATA` out D_BIT: fixed-point write data to `fht_top` iDATA_0..3
- `oADDR` out A_BIT: write address to `fht_top` iADDR_WR_0..3
- `oWE` out 4: one-hot bank write enable
- `oSTART` out 1: one-cycle start pulse to `fht_top` iSTART
- `iFHT_RDY` in 1: `fht_top` oRDY
- `oOVF` out 1: sticky overrun flag, set when iVALID is high while oREADY is low in LOAD-blocked states
- `iCLR_OVF` in 1: synchronous clear of oOVF

## Operation
- Conversion: `oDATA = {iADC, (D_BIT-ADC_WIDTH)'b0}`. The sample is the integer part and the fractional bits are zero. No rounding, no saturation.
- Sample counter `cnt` is (A_BIT+2) bits wide.
  - bank = cnt[1:0]
  - address = cnt[A_BIT+1:2]
- States:
  - LOAD:
    - `oREADY`=1.
    - On accept (iVALID & oREADY): register data, `oWE` = 1<<cnt[1:0], `oADDR` = cnt>>2, and cnt++.
    - If cnt == 4·2**A_BIT−1 at accept: cnt wraps to 0 and the state goes to FLUSH.
  - FLUSH: one cycle; the last write is presented; `oREADY`=0. Next state is START.
  - START: `oSTART`=1 for exactly one cycle. Next state is BUSY.
  - BUSY:
    - `oREADY`=0.
    - Waits for a registered rising edge of iFHT_RDY (previous 0, current 1), then returns to LOAD.
    - A level-high iFHT_RDY on entry is ignored until it has been seen low.
- Overrun: iVALID=1 in FLUSH, START or BUSY sets oOVF. The sample is dropped and cnt is unchanged. iCLR_OVF clears oOVF; if a set and a clear occur in the same cycle, set wins.
- Reset mid-frame clears cnt, drops the partial frame, and returns to LOAD. Bank contents already written are not erased.

## Timing
- Reset values: state=LOAD, cnt=0, `oREADY`=1, `oDATA`=0, `oADDR`=0, `oWE`=0, `oSTART`=0, `oOVF`=0, iFHT_RDY edge register=1 (prevents a false edge at startup).
- All outputs are registered.
  - A sample accepted at edge k drives oDATA/oADDR/oWE during cycle k→k+1.
  - oWE is high for exactly one cycle per accepted sample.
- Throughput: one sample per clock in LOAD. Back-to-back accepts are allowed.
- Last sample accepted at edge E:
  - its oWE is high in cycle E..E+1 (FLUSH)
  - oSTART is high in cycle E+1..E+2
  - BUSY is entered at E+2
  - RAM writes are therefore complete before the start pulse.
- End of frame: iFHT_RDY rises, is registered at edge R, and oREADY goes high after edge R+1.
- Minimum gap between frames: 2 cycles + FHT run time.

## Configuration
- `FHT_LOADER_BIT_REV_EN`:
  - Defined: `oADDR` = bit-reverse over A_BIT of cnt[A_BIT+1:2]. Bank selection is unchanged. Input order is then stored so the FHT reads it in bit-reversed sequence.
  - Undefined: `oADDR` = cnt[A_BIT+1:2] (natural order).

## Test plan
- Reset check: iRESET pulse, then check all outputs at reset values; oREADY=1 within 0 cycles of release.
- Single frame, A_BIT=2 (16 samples), iADC = 0..15 back-to-back, macro off:
  - sample 5 appears with oWE=4'b0010, oADDR=1, oDATA=5<<6
  - oSTART is high one cycle, two cycles after the 16th accept
  - oREADY=0 afterwards
- Same stream with `FHT_LOADER_BIT_REV_EN`: sample 5 (cnt>>2=1) appears with oADDR=2; sample 13 with oADDR=3; sample 4 with oWE=4'b0001, oADDR=2.
- Negative sample iADC=16'h8000 → oDATA=22'h200000. Stalled valid (iVALID toggling 1,0,1) writes only on accepted cycles.
- Overrun and completion:
  - iVALID=1 during BUSY → oOVF=1 and no oWE
  - iFHT_RDY held 1 from START: no return to LOAD
  - then drive iFHT_RDY 0→1: LOAD after 2 edges; iCLR_OVF clears oOVF
- Reset asserted after 7 of 16 samples: outputs reset asynchronously; the next frame starts at bank 0, addr 0; oSTART appears only after 16 fresh samples.
